cok_cevrimli_amb: RTL and testbench
===================================

Name: cok_cevrimli_amb

Overview:
- Parametrised, handshaked successor of the core's combinational ALU for the yurut stage.
- Supports configurable data width and registered results with add/sub flags.
- Shifts are multi-cycle, iterating KAYDIRMA_ADIM bits per cycle, which removes the full barrel shifter from the critical path.
- Uses valid/ready on input and output; a synchronous flush cancels work on pipeline redirect.

Parameters:
- VERI_BIT, 32: operand/result width; power of two, at least 8.
- KAYDIRMA_ADIM, 1: maximum shift distance per KAYDIR cycle; power of two, 1 to VERI_BIT.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- temizle_i  input  1  synchronous flush.
- kontrol_i  input  4  operation code; `AMB_* encodings from tanimlamalar.vh.
- deger1_i  input  VERI_BIT  operand 1.
- deger2_i  input  VERI_BIT  operand 2; shift amount is the low $clog2(VERI_BIT) bits.
- gecerli_i  input  1  operation valid.
- hazir_o  output  1  block can accept an operation.
- sonuc_o  output  VERI_BIT  registered result.
- sonuc_gecerli_o  output  1  result valid.
- sonuc_hazir_i  input  1  consumer accepts the result.
- sifir_o  output  1  result is zero (all ops).
- elde_o  output  1  adder carry-out (ADD/SUB only, else 0).
- tasma_o  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (async, rst_i=1):
  - state BOS.
  - sonuc_o=0, sonuc_gecerli_o=0, sifir_o=0, elde_o=0, tasma_o=0.
  - shift counter and working register cleared.
- States: BOS, KAYDIR.
- hazir_o = (state==BOS) & !temizle_i & (!sonuc_gecerli_o | sonuc_hazir_i).
- Accept happens when gecerli_i & hazir_o. Operands and kontrol_i are sampled only at accept.
- Output handshake: result transfers when sonuc_gecerli_o & sonuc_hazir_i.
  - sonuc_gecerli_o clears after transfer unless a new result loads the same cycle.
  - sonuc_o and the flags stay stable while sonuc_gecerli_o=1 and sonuc_hazir_i=0.
- Single-cycle ops (ADD, SUB, XOR, OR, AND, SLT, SLTU) and shifts with amount 0:
  - result and flags registered at the accept edge; sonuc_gecerli_o=1 next cycle (latency 1).
  - Throughput is one op per cycle when sonuc_hazir_i=1.
- ADD/SUB:
  - single adder; SUB = deger1 + ~deger2 + 1.
  - elde_o = carry out of bit VERI_BIT-1; for SUB, 1 means no borrow.
  - tasma_o = operand MSBs equal (after inversion) and result MSB differs.
  - Width wraps modulo 2^VERI_BIT.
- SLT: signed compare, result 1 or 0. SLTU: unsigned compare, result 1 or 0. Result is zero-extended.
- Shifts (SLL, SRL, SRA) with n>0:
  - on accept, go to KAYDIR with working register = deger1_i and kalan = n.
  - Each KAYDIR cycle shifts by min(KAYDIRMA_ADIM, kalan) and decrements kalan.
  - SRA replicates the MSB of the working register on every step.
  - After the step where kalan reaches 0: register the result, set sonuc_gecerli_o=1, return to BOS.
  - Latency = 1 + ceil(n / KAYDIRMA_ADIM); hazir_o=0 throughout KAYDIR.
- Undefined kontrol_i: result 0, sifir_o=1, elde_o=0, tasma_o=0, latency 1; no lock-up.
- temizle_i=1 (priority below reset):
  - next state BOS, sonuc_gecerli_o=0, kalan=0.
  - An operation presented the same cycle is not accepted (hazir_o=0).
  - sonuc_o and flag values are don't-care after flush.
- Simultaneous events:
  - Output transfer and new accept in the same cycle: the new result replaces the old with no bubble.
  - Flush together with a sonuc_hazir_i transfer: the transfer counts as done, and the result is dropped.

Optional Feature:
- Macro AMB_TEK_CEVRIM_KAYDIRMA_EN.
- Defined: shifts use a combinational barrel shifter, complete with latency 1 like the other ops, and KAYDIR is never entered. KAYDIRMA_ADIM is ignored.
- Undefined: iterative shifting as described above.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 (VERI_BIT=32) -> one cycle later sonuc_o=0x80000000, tasma_o=1, elde_o=0, sifir_o=0.
- SUB 5-5 then SLT 0xFFFFFFFF,1 then SLTU 0xFFFFFFFF,1, back-to-back with sonuc_hazir_i=1 -> results 0 (sifir_o=1, elde_o=1), 1, 0 on three consecutive cycles.
- SRA 0x80000000 by 4:
  - KAYDIRMA_ADIM=1: hazir_o low 4 cycles, result 0xF8000000 valid 5 cycles after accept.
  - KAYDIRMA_ADIM=4: valid 2 cycles after accept.
  - With the macro: valid 1 cycle after accept.
- Hold sonuc_hazir_i=0 with the XOR 0xFF00FF00,0x0F0F0F0F result pending for 3 cycles -> sonuc_o=0xF00FF00F stable and hazir_o=0; release -> transfer and new accept in the same cycle.
- SLL 1 by 31 (ADIM=1), assert temizle_i in the 3rd KAYDIR cycle -> next cycle state BOS, hazir_o=1, no sonuc_gecerli_o pulse.
- Assert rst_i asynchronously mid-shift between clock edges -> outputs zero immediately, hazir_o=1 after deassertion.

Source files
------------

// File: rtl/cok_cevrimli_amb.sv
// cok_cevrimli_amb: handshaked ALU for the yurut stage.
// Single-cycle add/sub/logic/compare with registered result and flags.
// Shifts iterate KAYDIRMA_ADIM bits per cycle in the KAYDIR state.
// Optional macro AMB_TEK_CEVRIM_KAYDIRMA_EN: shifts use a one-cycle
// barrel shifter and KAYDIR is never entered.
module cok_cevrimli_amb #(
   parameter int VERI_BIT      = 32,
   parameter int KAYDIRMA_ADIM = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                temizle_i,
   input  logic [3:0]          kontrol_i,
   input  logic [VERI_BIT-1:0] deger1_i,
   input  logic [VERI_BIT-1:0] deger2_i,
   input  logic                gecerli_i,
   output logic                hazir_o,
   output logic [VERI_BIT-1:0] sonuc_o,
   output logic                sonuc_gecerli_o,
   input  logic                sonuc_hazir_i,
   output logic                sifir_o,
   output logic                elde_o,
   output logic                tasma_o
);

   // Shift amount width and a counter one bit wider so the step size fits.
   localparam int SW = $clog2(VERI_BIT);
   localparam int KW = SW + 1;
   localparam logic [KW-1:0] ADIM_K = KW'(KAYDIRMA_ADIM);

   // Operation encodings shared with the core's AMB_* definitions.
   localparam logic [3:0] AMB_ADD  = 4'd0;
   localparam logic [3:0] AMB_SUB  = 4'd1;
   localparam logic [3:0] AMB_SLL  = 4'd2;
   localparam logic [3:0] AMB_SLT  = 4'd3;
   localparam logic [3:0] AMB_SLTU = 4'd4;
   localparam logic [3:0] AMB_XOR  = 4'd5;
   localparam logic [3:0] AMB_SRL  = 4'd6;
   localparam logic [3:0] AMB_SRA  = 4'd7;
   localparam logic [3:0] AMB_OR   = 4'd8;
   localparam logic [3:0] AMB_AND  = 4'd9;

   localparam logic [1:0] TUR_SLL = 2'd0;
   localparam logic [1:0] TUR_SRL = 2'd1;
   localparam logic [1:0] TUR_SRA = 2'd2;

`ifdef AMB_TEK_CEVRIM_KAYDIRMA_EN
   localparam bit COK_CEVRIM = 1'b0;
`else
   localparam bit COK_CEVRIM = 1'b1;
`endif

   typedef enum logic {BOS, KAYDIR} durum_t;

   durum_t              durum_q, durum_d;
   logic [VERI_BIT-1:0] sonuc_q, sonuc_d;
   logic [VERI_BIT-1:0] is_q, is_d;
   logic [KW-1:0]       kalan_q, kalan_d;
   logic [1:0]          tur_q, tur_d;
   logic                gecerli_q, gecerli_d;
   logic                sifir_q, sifir_d;
   logic                elde_q, elde_d;
   logic                tasma_q, tasma_d;

   // Single-cycle ALU datapath signals
   logic                       cikar;
   logic [VERI_BIT-1:0]        b_x;
   logic [VERI_BIT:0]          toplam;
   logic signed [VERI_BIT-1:0] d1_s, d2_s;
   logic [SW-1:0]              miktar;
   logic [VERI_BIT-1:0]        alu_sonuc;
   logic                       alu_elde, alu_tasma, kaydirma_op;
   logic [1:0]                 alu_tur;

   // Iterative shifter step signals
   logic [KW-1:0]              adim;
   logic signed [VERI_BIT-1:0] is_s;
   logic [VERI_BIT-1:0]        adim_sonuc;

   logic kabul;

   assign hazir_o = (durum_q == BOS) & ~temizle_i & (~gecerli_q | sonuc_hazir_i);
   assign kabul   = gecerli_i & hazir_o;

   assign sonuc_o         = sonuc_q;
   assign sonuc_gecerli_o = gecerli_q;
   assign sifir_o         = sifir_q;
   assign elde_o          = elde_q;
   assign tasma_o         = tasma_q;

   // Combinational ALU on the presented operands (used only at accept)
   always_comb begin
      cikar       = (kontrol_i == AMB_SUB);
      b_x         = cikar ? ~deger2_i : deger2_i;
      toplam      = {1'b0, deger1_i} + {1'b0, b_x} + {{VERI_BIT{1'b0}}, cikar};
      d1_s        = deger1_i;
      d2_s        = deger2_i;
      miktar      = deger2_i[SW-1:0];
      alu_sonuc   = '0;
      alu_elde    = 1'b0;
      alu_tasma   = 1'b0;
      kaydirma_op = 1'b0;
      alu_tur     = TUR_SLL;
      case (kontrol_i)
         AMB_ADD, AMB_SUB: begin
            alu_sonuc = toplam[VERI_BIT-1:0];
            alu_elde  = toplam[VERI_BIT];
            alu_tasma = (deger1_i[VERI_BIT-1] == b_x[VERI_BIT-1]) &
                        (toplam[VERI_BIT-1] != deger1_i[VERI_BIT-1]);
         end
         AMB_XOR:  alu_sonuc = deger1_i ^ deger2_i;
         AMB_OR:   alu_sonuc = deger1_i | deger2_i;
         AMB_AND:  alu_sonuc = deger1_i & deger2_i;
         AMB_SLT:  alu_sonuc = {{(VERI_BIT-1){1'b0}}, (d1_s < d2_s)};
         AMB_SLTU: alu_sonuc = {{(VERI_BIT-1){1'b0}}, (deger1_i < deger2_i)};
         AMB_SLL: begin
            kaydirma_op = 1'b1;
            alu_tur     = TUR_SLL;
            alu_sonuc   = deger1_i << miktar;
         end
         AMB_SRL: begin
            kaydirma_op = 1'b1;
            alu_tur     = TUR_SRL;
            alu_sonuc   = deger1_i >> miktar;
         end
         AMB_SRA: begin
            kaydirma_op = 1'b1;
            alu_tur     = TUR_SRA;
            alu_sonuc   = $unsigned(d1_s >>> miktar);
         end
         default: alu_sonuc = '0;
      endcase
   end

   // One KAYDIR step: shift the working register by min(ADIM, kalan)
   always_comb begin
      adim = (kalan_q < ADIM_K) ? kalan_q : ADIM_K;
      is_s = is_q;
      case (tur_q)
         TUR_SRL: adim_sonuc = is_q >> adim;
         TUR_SRA: adim_sonuc = $unsigned(is_s >>> adim);
         default: adim_sonuc = is_q << adim;
      endcase
   end

   // Next-state, result loading and output handshake
   always_comb begin
      durum_d   = durum_q;
      sonuc_d   = sonuc_q;
      is_d      = is_q;
      kalan_d   = kalan_q;
      tur_d     = tur_q;
      gecerli_d = gecerli_q;
      sifir_d   = sifir_q;
      elde_d    = elde_q;
      tasma_d   = tasma_q;

      if (gecerli_q & sonuc_hazir_i)
         gecerli_d = 1'b0;

      if (temizle_i) begin
         durum_d   = BOS;
         gecerli_d = 1'b0;
         kalan_d   = '0;
      end else begin
         case (durum_q)
            BOS: begin
               if (kabul) begin
                  if (COK_CEVRIM && kaydirma_op && (miktar != '0)) begin
                     durum_d = KAYDIR;
                     is_d    = deger1_i;
                     kalan_d = {1'b0, miktar};
                     tur_d   = alu_tur;
                  end else begin
                     sonuc_d   = alu_sonuc;
                     sifir_d   = (alu_sonuc == '0);
                     elde_d    = alu_elde;
                     tasma_d   = alu_tasma;
                     gecerli_d = 1'b1;
                  end
               end
            end
            KAYDIR: begin
               is_d    = adim_sonuc;
               kalan_d = kalan_q - adim;
               if (kalan_q == adim) begin
                  durum_d   = BOS;
                  sonuc_d   = adim_sonuc;
                  sifir_d   = (adim_sonuc == '0);
                  elde_d    = 1'b0;
                  tasma_d   = 1'b0;
                  gecerli_d = 1'b1;
               end
            end
            default: durum_d = BOS;
         endcase
      end
   end

   // State and result registers with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q   <= BOS;
         sonuc_q   <= '0;
         is_q      <= '0;
         kalan_q   <= '0;
         tur_q     <= TUR_SLL;
         gecerli_q <= 1'b0;
         sifir_q   <= 1'b0;
         elde_q    <= 1'b0;
         tasma_q   <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         sonuc_q   <= sonuc_d;
         is_q      <= is_d;
         kalan_q   <= kalan_d;
         tur_q     <= tur_d;
         gecerli_q <= gecerli_d;
         sifir_q   <= sifir_d;
         elde_q    <= elde_d;
         tasma_q   <= tasma_d;
      end
   end

endmodule

// File: tb/tb_cok_cevrimli_amb.sv
// Directed bench for cok_cevrimli_amb: main instance with KAYDIRMA_ADIM=1
// and a second instance with KAYDIRMA_ADIM=4 sharing the same inputs.
module tb_cok_cevrimli_amb;

   localparam logic [3:0] AMB_ADD  = 4'd0;
   localparam logic [3:0] AMB_SUB  = 4'd1;
   localparam logic [3:0] AMB_SLL  = 4'd2;
   localparam logic [3:0] AMB_SLT  = 4'd3;
   localparam logic [3:0] AMB_SLTU = 4'd4;
   localparam logic [3:0] AMB_XOR  = 4'd5;
   localparam logic [3:0] AMB_SRL  = 4'd6;
   localparam logic [3:0] AMB_SRA  = 4'd7;
   localparam logic [3:0] AMB_AND  = 4'd9;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        temizle_i = 1'b0;
   logic [3:0]  kontrol_i = 4'd0;
   logic [31:0] deger1_i = '0;
   logic [31:0] deger2_i = '0;
   logic        gecerli_i = 1'b0;
   logic        sonuc_hazir_i = 1'b1;

   logic        hazir_o, sonuc_gecerli_o, sifir_o, elde_o, tasma_o;
   logic [31:0] sonuc_o;
   logic        hazir4, gecerli4, sifir4, elde4, tasma4;
   logic [31:0] sonuc4;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_i = ~clk_i;

   cok_cevrimli_amb #(.VERI_BIT(32), .KAYDIRMA_ADIM(1)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .temizle_i(temizle_i), .kontrol_i(kontrol_i),
      .deger1_i(deger1_i), .deger2_i(deger2_i), .gecerli_i(gecerli_i),
      .hazir_o(hazir_o), .sonuc_o(sonuc_o), .sonuc_gecerli_o(sonuc_gecerli_o),
      .sonuc_hazir_i(sonuc_hazir_i), .sifir_o(sifir_o), .elde_o(elde_o), .tasma_o(tasma_o));

   cok_cevrimli_amb #(.VERI_BIT(32), .KAYDIRMA_ADIM(4)) u_dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .temizle_i(temizle_i), .kontrol_i(kontrol_i),
      .deger1_i(deger1_i), .deger2_i(deger2_i), .gecerli_i(gecerli_i),
      .hazir_o(hazir4), .sonuc_o(sonuc4), .sonuc_gecerli_o(gecerli4),
      .sonuc_hazir_i(sonuc_hazir_i), .sifir_o(sifir4), .elde_o(elde4), .tasma_o(tasma4));

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic present(input logic [3:0] k, input logic [31:0] a, input logic [31:0] b);
      kontrol_i = k;
      deger1_i  = a;
      deger2_i  = b;
      gecerli_i = 1'b1;
   endtask

   task automatic idle();
      gecerli_i = 1'b0;
      sonuc_hazir_i = 1'b1;
      temizle_i = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      #1;
      tests_run++;
      if ({sonuc_o, sonuc_gecerli_o, sifir_o, elde_o, tasma_o} !== 36'd0) begin
         $display("FAIL reset_outputs: got %h/%b%b%b%b required 0", sonuc_o, sonuc_gecerli_o, sifir_o, elde_o, tasma_o);
         tests_failed++;
      end
      tick();
      rst_i = 1'b0;
      tick();
      tests_run++;
      if (hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0) begin
         $display("FAIL reset_hazir: got hazir=%b gecerli=%b required 1/0", hazir_o, sonuc_gecerli_o);
         tests_failed++;
      end
   endtask

   task automatic test_add();
      present(AMB_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      #1;
      tests_run++;
      if (hazir_o !== 1'b1) begin
         $display("FAIL add_hazir: got %b required 1", hazir_o);
         tests_failed++;
      end
      tick();
      gecerli_i = 1'b0;
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'h8000_0000 || tasma_o !== 1'b1 ||
          elde_o !== 1'b0 || sifir_o !== 1'b0) begin
         $display("FAIL add_overflow: got v=%b %h t=%b e=%b z=%b required 1 80000000 1 0 0",
                  sonuc_gecerli_o, sonuc_o, tasma_o, elde_o, sifir_o);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (sonuc_gecerli_o !== 1'b0) begin
         $display("FAIL add_transfer: got gecerli=%b required 0", sonuc_gecerli_o);
         tests_failed++;
      end
      idle();
   endtask

   task automatic test_back_to_back();
      present(AMB_SUB, 32'd5, 32'd5);
      tick();
      present(AMB_SLT, 32'hFFFF_FFFF, 32'd1);
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd0 || sifir_o !== 1'b1 || elde_o !== 1'b1 || tasma_o !== 1'b0) begin
         $display("FAIL b2b_sub: got v=%b %h z=%b e=%b t=%b required 1 0 1 1 0",
                  sonuc_gecerli_o, sonuc_o, sifir_o, elde_o, tasma_o);
         tests_failed++;
      end
      tick();
      present(AMB_SLTU, 32'hFFFF_FFFF, 32'd1);
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd1 || sifir_o !== 1'b0 || elde_o !== 1'b0) begin
         $display("FAIL b2b_slt: got v=%b %h z=%b e=%b required 1 1 0 0", sonuc_gecerli_o, sonuc_o, sifir_o, elde_o);
         tests_failed++;
      end
      tick();
      gecerli_i = 1'b0;
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd0 || sifir_o !== 1'b1) begin
         $display("FAIL b2b_sltu: got v=%b %h z=%b required 1 0 1", sonuc_gecerli_o, sonuc_o, sifir_o);
         tests_failed++;
      end
      idle();
   endtask

   task automatic test_hold();
      sonuc_hazir_i = 1'b0;
      present(AMB_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
      tick();
      present(AMB_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'hF00F_F00F || hazir_o !== 1'b0) begin
            $display("FAIL hold_stable[%0d]: got v=%b %h hazir=%b required 1 f00ff00f 0",
                     i, sonuc_gecerli_o, sonuc_o, hazir_o);
            tests_failed++;
         end
         tick();
      end
      sonuc_hazir_i = 1'b1;
      #1;
      tests_run++;
      if (hazir_o !== 1'b1) begin
         $display("FAIL hold_release_hazir: got %b required 1", hazir_o);
         tests_failed++;
      end
      tick();
      gecerli_i = 1'b0;
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'h00F0_00F0) begin
         $display("FAIL hold_replace: got v=%b %h required 1 00f000f0", sonuc_gecerli_o, sonuc_o);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (sonuc_gecerli_o !== 1'b0) begin
         $display("FAIL hold_drain: got gecerli=%b required 0", sonuc_gecerli_o);
         tests_failed++;
      end
      idle();
   endtask

   task automatic test_sra();
      int lat1;
      int lat4;
`ifdef AMB_TEK_CEVRIM_KAYDIRMA_EN
      lat1 = 1;
      lat4 = 1;
`else
      lat1 = 5;
      lat4 = 2;
`endif
      present(AMB_SRA, 32'h8000_0000, 32'd4);
      tick();
      gecerli_i = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         #1;
         tests_run++;
         if (sonuc_gecerli_o !== (i == lat1) || hazir_o !== (i >= lat1) ||
             gecerli4 !== (i == lat4)) begin
            $display("FAIL sra_timing[%0d]: got v=%b hazir=%b v4=%b required %b %b %b",
                     i, sonuc_gecerli_o, hazir_o, gecerli4, (i == lat1), (i >= lat1), (i == lat4));
            tests_failed++;
         end
         if (i == lat1) begin
            tests_run++;
            if (sonuc_o !== 32'hF800_0000 || sifir_o !== 1'b0) begin
               $display("FAIL sra_result: got %h z=%b required f8000000 0", sonuc_o, sifir_o);
               tests_failed++;
            end
         end
         if (i == lat4) begin
            tests_run++;
            if (sonuc4 !== 32'hF800_0000) begin
               $display("FAIL sra_result4: got %h required f8000000", sonuc4);
               tests_failed++;
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_shift_zero_and_undef();
      // amount field 0x20 has low five bits 0: single-cycle pass-through
      present(AMB_SRL, 32'h0000_00F0, 32'h0000_0020);
      tick();
      present(AMB_SUB, 32'd5, 32'd3);
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'h0000_00F0) begin
         $display("FAIL shift_zero: got v=%b %h required 1 000000f0", sonuc_gecerli_o, sonuc_o);
         tests_failed++;
      end
      tick();
      present(4'hF, 32'h1234_5678, 32'h0000_0001);
      tests_run++;
      if (sonuc_o !== 32'd2 || elde_o !== 1'b1 || tasma_o !== 1'b0) begin
         $display("FAIL sub_borrow: got %h e=%b t=%b required 2 1 0", sonuc_o, elde_o, tasma_o);
         tests_failed++;
      end
      tick();
      present(AMB_ADD, 32'd2, 32'd3);
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd0 || sifir_o !== 1'b1 || elde_o !== 1'b0 || tasma_o !== 1'b0) begin
         $display("FAIL undef_op: got v=%b %h z=%b e=%b t=%b required 1 0 1 0 0",
                  sonuc_gecerli_o, sonuc_o, sifir_o, elde_o, tasma_o);
         tests_failed++;
      end
      tick();
      gecerli_i = 1'b0;
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd5 || sifir_o !== 1'b0) begin
         $display("FAIL undef_recover: got v=%b %h z=%b required 1 5 0", sonuc_gecerli_o, sonuc_o, sifir_o);
         tests_failed++;
      end
      idle();
   endtask

   task automatic test_flush();
      bit seen;
`ifdef AMB_TEK_CEVRIM_KAYDIRMA_EN
      sonuc_hazir_i = 1'b0;
      present(AMB_SLL, 32'd1, 32'd31);
      tick();
      gecerli_i = 1'b0;
      tests_run++;
      if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'h8000_0000) begin
         $display("FAIL flush_pre: got v=%b %h required 1 80000000", sonuc_gecerli_o, sonuc_o);
         tests_failed++;
      end
      temizle_i = 1'b1;
`else
      present(AMB_SLL, 32'd1, 32'd31);
      tick();
      gecerli_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         #1;
         tests_run++;
         if (hazir_o !== 1'b0 || sonuc_gecerli_o !== 1'b0) begin
            $display("FAIL flush_kaydir[%0d]: got hazir=%b v=%b required 0 0", i, hazir_o, sonuc_gecerli_o);
            tests_failed++;
         end
         if (i < 3) tick();
      end
      temizle_i = 1'b1;
      gecerli_i = 1'b1;
`endif
      #1;
      tests_run++;
      if (hazir_o !== 1'b0) begin
         $display("FAIL flush_hazir_low: got %b required 0", hazir_o);
         tests_failed++;
      end
      tick();
      temizle_i = 1'b0;
      gecerli_i = 1'b0;
      sonuc_hazir_i = 1'b1;
      #1;
      tests_run++;
      if (hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0 || hazir4 !== 1'b1) begin
         $display("FAIL flush_bos: got hazir=%b v=%b hazir4=%b required 1 0 1", hazir_o, sonuc_gecerli_o, hazir4);
         tests_failed++;
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sonuc_gecerli_o || gecerli4) seen = 1'b1;
         tick();
      end
      tests_run++;
      if (seen !== 1'b0) begin
         $display("FAIL flush_no_pulse: got pulse=%b required 0", seen);
         tests_failed++;
      end
      idle();
   endtask

   task automatic test_async_reset();
      bit seen;
      present(AMB_SUB, 32'd5, 32'd3);
      tick();
      present(AMB_SLL, 32'd1, 32'd31);
      tick();
      gecerli_i = 1'b0;
      tick();
      tests_run++;
`ifdef AMB_TEK_CEVRIM_KAYDIRMA_EN
      if (sonuc_o !== 32'h8000_0000) begin
         $display("FAIL areset_pre: got %h required 80000000", sonuc_o);
         tests_failed++;
      end
`else
      if (sonuc_o !== 32'd2 || elde_o !== 1'b1 || hazir_o !== 1'b0) begin
         $display("FAIL areset_pre: got %h e=%b hazir=%b required 2 1 0", sonuc_o, elde_o, hazir_o);
         tests_failed++;
      end
`endif
      #3;
      rst_i = 1'b1;
      #1;
      tests_run++;
      if ({sonuc_o, sonuc_gecerli_o, sifir_o, elde_o, tasma_o} !== 36'd0 || sonuc4 !== 32'd0) begin
         $display("FAIL areset_zero: got %h/%b%b%b%b sonuc4=%h required 0",
                  sonuc_o, sonuc_gecerli_o, sifir_o, elde_o, tasma_o, sonuc4);
         tests_failed++;
      end
      #2;
      rst_i = 1'b0;
      #1;
      tests_run++;
      if (hazir_o !== 1'b1 || hazir4 !== 1'b1) begin
         $display("FAIL areset_hazir: got %b/%b required 1/1", hazir_o, hazir4);
         tests_failed++;
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (sonuc_gecerli_o || gecerli4) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
         $display("FAIL areset_no_pulse: got pulse=%b required 0", seen);
         tests_failed++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_hold();
      test_sra();
      test_shift_zero_and_undef();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
